// File: rtl/mcb_ref_exec.sv
// Refresh command executor: takes the SDRAM command bus from the user engine,
// closes open rows with PRECHARGE ALL and issues REF_NUM AUTO REFRESH commands.
//
//   state  | meaning
//   IDLE   | bus owned by user engine, waiting for a refresh request
//   PRE    | PRECHARGE ALL on the pins this cycle
//   TRP    | waiting out tRP after the precharge
//   REF    | AUTO REFRESH on the pins this cycle
//   TRFC   | waiting out tRFC; then next REF or back to IDLE
module mcb_ref_exec #(
  parameter int CtRP    = 3,
  parameter int CtRFC   = 10,
  parameter int REF_NUM = 1,
  parameter int CNT_W   = 4
) (
  input  logic mcb_clk,
  input  logic mcb_rst,
  input  logic mcb_sclr_n,
  input  logic i_ready,
  input  logic r_ref_req,
  input  logic r_ref_alert,
  input  logic u_busy,
  input  logic u_bank_open,
  output logic c_ready,
  output logic c_ref,
  output logic ref_own,
  output logic u_hold,
  output logic cmd_cs_n,
  output logic cmd_ras_n,
  output logic cmd_cas_n,
  output logic cmd_we_n,
  output logic cmd_a10,
  output logic err_collision
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_TRP  = 3'd2;
  localparam logic [2:0] S_REF  = 3'd3;
  localparam logic [2:0] S_TRFC = 3'd4;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  // REF_NUM=8 truncates to 0, matching the 3-bit refresh counter wrapping after the 8th REF
  localparam logic [2:0] REF_LAST = 3'(REF_NUM);
  localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'(CtRP - 1);
  localparam logic [CNT_W-1:0] TRFC_LOAD = CNT_W'(CtRFC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [2:0]       rcnt_q, rcnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             a10_q, a10_d;
  logic             c_ref_q, ref_own_q, err_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = (tcnt_q != '0) ? tcnt_q - CNT_W'(1) : tcnt_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE: begin
        rcnt_d = '0;
        if (r_ref_req && i_ready && !u_busy)
          state_d = u_bank_open ? S_PRE : S_REF;
      end
      S_PRE:  state_d = S_TRP;
      S_TRP:  if (tcnt_q == '0) state_d = S_REF;
      S_REF: begin
        state_d = S_TRFC;
        rcnt_d  = rcnt_q + 3'd1;
      end
      S_TRFC: if (tcnt_q == '0) state_d = (rcnt_q == REF_LAST) ? S_IDLE : S_REF;
      default: state_d = S_IDLE;
    endcase

    if (!i_ready || !mcb_sclr_n) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
      rcnt_d  = '0;
    end

    if (state_d == S_PRE) tcnt_d = TRP_LOAD;
    if (state_d == S_REF) tcnt_d = TRFC_LOAD;

    cmd_d = CMD_NOP;
    a10_d = 1'b0;
    if (state_d == S_PRE) begin
      cmd_d = CMD_PRE;
      a10_d = 1'b1;
    end else if (state_d == S_REF) begin
      cmd_d = CMD_REF;
    end
  end

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      rcnt_q    <= '0;
      cmd_q     <= CMD_DESEL;
      a10_q     <= 1'b0;
      c_ref_q   <= 1'b0;
      ref_own_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      rcnt_q    <= rcnt_d;
      cmd_q     <= cmd_d;
      a10_q     <= a10_d;
      c_ref_q   <= (state_d == S_REF);
      ref_own_q <= (state_d != S_IDLE);
      err_q     <= err_q | (u_busy & ref_own_q);
    end
  end

  assign c_ready = (state_q == S_IDLE) & ~u_busy & i_ready & mcb_sclr_n & ~mcb_rst;
  assign c_ref         = c_ref_q;
  assign ref_own       = ref_own_q;
  assign u_hold        = r_ref_alert | ref_own_q;
  assign cmd_cs_n      = cmd_q[3];
  assign cmd_ras_n     = cmd_q[2];
  assign cmd_cas_n     = cmd_q[1];
  assign cmd_we_n      = cmd_q[0];
  assign cmd_a10       = a10_q;
  assign err_collision = err_q;

endmodule

// File: tb/tb_mcb_ref_exec.sv
// Bench for mcb_ref_exec: two instances (REF_NUM=1 and REF_NUM=4) share stimulus
// and are compared each cycle against a timeline model of the refresh sequence.
module tb_mcb_ref_exec;
  localparam int CtRP  = 3;
  localparam int CtRFC = 10;
  localparam int RN [2] = '{1, 4};

  logic mcb_clk = 1'b0;
  logic mcb_rst, mcb_sclr_n, i_ready, r_ref_req, r_ref_alert, u_busy, u_bank_open;
  logic [1:0] c_ready, c_ref, ref_own, u_hold, cs_n, ras_n, cas_n, we_n, a10, err;
  logic [1:0][8:0] obs;

  int checks = 0;
  int passed = 0;

  always #5 mcb_clk = ~mcb_clk;

  mcb_ref_exec #(.CtRP(CtRP), .CtRFC(CtRFC), .REF_NUM(1), .CNT_W(4)) dut1 (
    .mcb_clk(mcb_clk), .mcb_rst(mcb_rst), .mcb_sclr_n(mcb_sclr_n), .i_ready(i_ready),
    .r_ref_req(r_ref_req), .r_ref_alert(r_ref_alert), .u_busy(u_busy), .u_bank_open(u_bank_open),
    .c_ready(c_ready[0]), .c_ref(c_ref[0]), .ref_own(ref_own[0]), .u_hold(u_hold[0]),
    .cmd_cs_n(cs_n[0]), .cmd_ras_n(ras_n[0]), .cmd_cas_n(cas_n[0]), .cmd_we_n(we_n[0]),
    .cmd_a10(a10[0]), .err_collision(err[0]));

  mcb_ref_exec #(.CtRP(CtRP), .CtRFC(CtRFC), .REF_NUM(4), .CNT_W(4)) dut4 (
    .mcb_clk(mcb_clk), .mcb_rst(mcb_rst), .mcb_sclr_n(mcb_sclr_n), .i_ready(i_ready),
    .r_ref_req(r_ref_req), .r_ref_alert(r_ref_alert), .u_busy(u_busy), .u_bank_open(u_bank_open),
    .c_ready(c_ready[1]), .c_ref(c_ref[1]), .ref_own(ref_own[1]), .u_hold(u_hold[1]),
    .cmd_cs_n(cs_n[1]), .cmd_ras_n(ras_n[1]), .cmd_cas_n(cas_n[1]), .cmd_we_n(we_n[1]),
    .cmd_a10(a10[1]), .err_collision(err[1]));

  // {cs,ras,cas,we,a10, c_ref, ref_own, u_hold, c_ready}
  assign obs[0] = {cs_n[0], ras_n[0], cas_n[0], we_n[0], a10[0], c_ref[0], ref_own[0], u_hold[0], c_ready[0]};
  assign obs[1] = {cs_n[1], ras_n[1], cas_n[1], we_n[1], a10[1], c_ref[1], ref_own[1], u_hold[1], c_ready[1]};

  // Expected outputs k cycles after the cycle a request was accepted (k=0: still idle)
  function automatic logic [8:0] exp_vec(int k, bit open, int rn, logic alert, logic idle_rdy);
    int t0, len;
    logic [4:0] pins;
    logic own, cref;
    t0   = open ? CtRP : 0;
    len  = t0 + rn * CtRFC;
    own  = (k >= 1) && (k <= len);
    pins = 5'b01110;
    cref = 1'b0;
    if (own && open && k == 1) pins = 5'b00101;
    else if (own && (k - 1 - t0) >= 0 && ((k - 1 - t0) % CtRFC) == 0) begin
      pins = 5'b00010;
      cref = 1'b1;
    end
    return {pins, cref, own, alert | own, idle_rdy & ~own};
  endfunction

  task automatic step();
    @(posedge mcb_clk);
    #1;
  endtask

  task automatic test_reset();
    mcb_rst = 1'b1; mcb_sclr_n = 1'b1; i_ready = 1'b1; r_ref_req = 1'b0;
    r_ref_alert = 1'b0; u_busy = 1'b0; u_bank_open = 1'b0;
    step(); step();
    @(negedge mcb_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 9'b11110_0000 || err[d] !== 1'b0)
        $display("FAIL reset dut%0d got %b err %b exp 111100000 err 0", d, obs[d], err[d]);
      else passed++;
    end
    step(); mcb_rst = 1'b0;
    @(negedge mcb_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 9'b11110_0001) $display("FAIL reset_release dut%0d got %b exp 111100001", d, obs[d]);
      else passed++;
    end
    step();
    @(negedge mcb_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 9'b01110_0001) $display("FAIL first_nop dut%0d got %b exp 011100001", d, obs[d]);
      else passed++;
    end
  endtask

  // One full request; busy_cycles of u_busy blocking the pending request first
  task automatic test_refresh(input bit open, input int busy_cycles);
    int gap, len1, lenmax;
    logic [8:0] e;
    gap    = $urandom_range(0, 3);
    len1   = (open ? CtRP : 0) + RN[0] * CtRFC;
    lenmax = (open ? CtRP : 0) + RN[1] * CtRFC;
    u_bank_open = open;
    for (int i = 0; i < gap; i++) begin
      step(); r_ref_req = 1'b0; r_ref_alert = 1'($urandom);
      @(negedge mcb_clk);
      for (int d = 0; d < 2; d++) begin
        e = exp_vec(0, open, RN[d], r_ref_alert, 1'b1);
        checks++;
        if (obs[d] !== e) $display("FAIL gap dut%0d got %b exp %b", d, obs[d], e);
        else passed++;
      end
    end
    for (int i = 0; i < busy_cycles; i++) begin
      step(); r_ref_req = 1'b1; u_busy = 1'b1; r_ref_alert = 1'($urandom);
      @(negedge mcb_clk);
      for (int d = 0; d < 2; d++) begin
        e = exp_vec(0, open, RN[d], r_ref_alert, 1'b0);
        checks++;
        if (obs[d] !== e) $display("FAIL busy_wait dut%0d got %b exp %b", d, obs[d], e);
        else passed++;
      end
    end
    step(); r_ref_req = 1'b1; u_busy = 1'b0; r_ref_alert = 1'($urandom);
    for (int k = 0; k <= lenmax + 1; k++) begin
      if (k > 0) begin
        step();
        r_ref_req   = (k <= len1) ? 1'($urandom) : 1'b0;
        r_ref_alert = 1'($urandom);
        u_bank_open = 1'($urandom);
      end
      @(negedge mcb_clk);
      for (int d = 0; d < 2; d++) begin
        e = exp_vec(k, open, RN[d], r_ref_alert, 1'b1);
        checks++;
        if (obs[d] !== e) $display("FAIL seq open=%0d k=%0d dut%0d got %b exp %b", open, k, d, obs[d], e);
        else passed++;
      end
    end
    r_ref_alert = 1'b0;
  endtask

  task automatic test_iready_drop();
    u_bank_open = 1'b0;
    step(); r_ref_req = 1'b1;
    step(); r_ref_req = 1'b0;
    step();
    step(); i_ready = 1'b0;
    @(negedge mcb_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 9'b01110_0110) $display("FAIL iready_low dut%0d got %b exp 011100110", d, obs[d]);
      else passed++;
    end
    for (int k = 4; k < 16; k++) begin
      step(); i_ready = 1'b1;
      @(negedge mcb_clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== 9'b01110_0001) $display("FAIL iready_abort k=%0d dut%0d got %b exp 011100001", k, d, obs[d]);
        else passed++;
      end
    end
  endtask

  task automatic test_rst_in_trp();
    logic [8:0] e [3];
    e = '{9'b11110_0000, 9'b11110_0001, 9'b01110_0001};
    u_bank_open = 1'b1;
    step(); r_ref_req = 1'b1;
    step(); r_ref_req = 1'b0;
    step(); mcb_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); mcb_rst = (i == 0);
      @(negedge mcb_clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== e[i] || err[d] !== 1'b0)
          $display("FAIL rst_trp i=%0d dut%0d got %b err %b exp %b err 0", i, d, obs[d], err[d], e[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_collision();
    logic [1:0] ex [6];
    ex = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    u_bank_open = 1'b0;
    step(); r_ref_req = 1'b1;
    step(); r_ref_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      u_busy     = (i == 0);
      mcb_sclr_n = !(i == 2 || i == 3);
      mcb_rst    = (i == 4);
      @(negedge mcb_clk);
      checks++;
      if (err !== ex[i]) $display("FAIL collision i=%0d got %b exp %b", i, err, ex[i]);
      else passed++;
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 9'b11110_0001) $display("FAIL collision_rst dut%0d got %b exp 111100001", d, obs[d]);
      else passed++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) test_refresh(1'($urandom), $urandom_range(0, 2));
  endtask

  initial begin
    test_reset();
    test_refresh(1'b0, 0);
    test_refresh(1'b1, 0);
    test_refresh(1'b0, 3);
    test_iready_drop();
    test_rst_in_trp();
    test_collision();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mcb_ref_exec.md
# mcb_ref_exec

Refresh command executor for the sdrc_lite SDR SDRAM back-end: it consumes the refresh request/alert produced by the refresh interval timer, and holds off the user access engine. It takes ownership of the SDRAM command bus and issues PRECHARGE ALL (when any row is open) followed by REF_NUM AUTO REFRESH commands with tRP/tRFC spacing. It returns `c_ready` and `c_ref` to the timer, closing the refresh handshake loop.

## Interface
- CtRP, 3: tRP in mcb_clk cycles, min 2
- CtRFC, 10: tRFC in mcb_clk cycles, min 2
- REF_NUM, 1: AUTO REFRESH commands per request, 1..8
- CNT_W, 4: width of timing counter; 2^CNT_W > max(CtRP, CtRFC)
- mcb_clk  in  1  controller clock
- mcb_rst  in  1  synchronous, active-high reset
- mcb_sclr_n  in  1  synchronous clear, active-low; same effect as reset except `err_collision`
- i_ready  in  1  SDRAM init complete
- r_ref_req  in  1  refresh request from interval timer
- r_ref_alert  in  1  refresh due (timer)
- u_busy  in  1  user access engine mid-access
- u_bank_open  in  1  at least one row open
- c_ready  out  1  command path idle; to timer
- c_ref  out  1  one-cycle pulse per AUTO REFRESH issued; clears timer
- ref_own  out  1  this block owns command bus (mux select)
- u_hold  out  1  user engine must not start a new access
- cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n  out  1 each  SDRAM command
- cmd_a10  out  1  A10 (1 = precharge all)
- err_collision  out  1  sticky: u_busy seen high while ref_own

## Operation
- States: IDLE, PRE, TRP, REF, TRFC.
- IDLE → PRE: `r_ref_req & i_ready & ~u_busy & u_bank_open`; IDLE → REF: same conditions with `~u_bank_open`.
- PRE: one cycle, then go to TRP.
- TRP: wait until CtRP cycles after PRE have elapsed, then go to REF.
- REF: one cycle, then go to TRFC.
- TRFC: wait until CtRFC cycles after REF have elapsed. Then go to REF if fewer than REF_NUM refreshes have been issued for this request; otherwise go to IDLE.
- Timing counter loads on PRE/REF entry and decrements to 0; it does not wrap.
- Refresh counter (3 bits) clears in IDLE and increments on each REF.
- Command encoding, registered and decoded from next state:
  - DESELECT = 1111
  - NOP = 0111
  - PRE ALL = 0010 with a10=1
  - REF = 0001
  - Every state other than PRE/REF drives NOP with a10=0.
- `ref_own` = state != IDLE (registered).
- `u_hold` = `r_ref_alert | ref_own`.
- `c_ready` = state==IDLE & ~u_busy & i_ready & mcb_sclr_n & ~mcb_rst (combinational).
- `c_ref` = registered pulse, high exactly in cycles where the command pins show REF.
- `i_ready` low or `mcb_sclr_n` low in any state forces the following:
  - IDLE next cycle, counters cleared, pins NOP.
  - Any in-flight sequence is abandoned, with no c_ref for it.
- `r_ref_req` in any non-IDLE state is ignored; the timer deasserts it two cycles after `c_ref`.
- Simultaneous `u_busy` rise and `r_ref_req` in IDLE: the user wins and the refresh waits.
- `err_collision` sets when `u_busy` is high while `ref_own` is high, and clears only on `mcb_rst`.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - `ref_own`, `c_ref`, `c_ready`, `err_collision` = 0.
  - cmd pins DESELECT (1111), a10=0.
- Out of reset, the pins go to NOP on the first clock.
- Latency: request accepted in cycle N → first command on pins in cycle N+1; `ref_own` high from N+1.
- PRE on pins in cycle T → REF on pins in cycle T+CtRP.
- REF in cycle T → next REF at T+CtRFC, or `ref_own` low / IDLE at T+CtRFC.
- Bus hold times:
  - Open bank: `ref_own` high for CtRP + REF_NUM·CtRFC cycles.
  - Closed bank: `ref_own` high for REF_NUM·CtRFC cycles.

## Test plan
- **Closed bank, REF_NUM=1, CtRFC=10:** pulse `r_ref_req` in cycle 5 → REF (0001) and `c_ref`=1 in cycle 6 only; NOP cycles 7-15; `ref_own` 6..15; `c_ready` high again cycle 16.
- **Open bank, CtRP=3:** request at cycle 5 → PRE ALL with a10=1 at cycle 6, REF at cycle 9, `ref_own` low at cycle 19.
- **REF_NUM=4, closed bank:** REF at cycles 6, 16, 26, 36; four `c_ref` pulses; IDLE at cycle 46.
- **`u_busy` high when request arrives:** no command and `c_ready`=0 until `u_busy` falls; `u_hold`=1 while `r_ref_alert`=1.
- **`i_ready` dropped during TRFC:** IDLE and NOP next cycle, no further REF. **`mcb_rst` during TRP:** pins DESELECT and all outputs 0 next cycle.
- **`u_busy` forced high while `ref_own`:** `err_collision`=1 and stays 1 through `mcb_sclr_n` low; clears on `mcb_rst`.
